// File: rtl/tec_ctrl_seq_pkg.sv
// Shared types and encodings for the second-generation teaching-CPU controller:
// state enum, opcodes, ALU codes, console modes and the datapath control bundle.
package tec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CON   = 3'd1,
    ST_FETCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_INT   = 3'd4,
    ST_HALT  = 3'd5
  } fsm_t;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_INC = 4'b0100;
  localparam logic [3:0] OP_LD  = 4'b0101;
  localparam logic [3:0] OP_ST  = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_EI  = 4'b1011;
  localparam logic [3:0] OP_DI  = 4'b1100;
  localparam logic [3:0] OP_STP = 4'b1110;

  // ALU function codes; the logic-pass codes are used with m = 1
  localparam logic [3:0] S_ADD    = 4'b1001;
  localparam logic [3:0] S_SUB    = 4'b0110;
  localparam logic [3:0] S_AND    = 4'b1011;
  localparam logic [3:0] S_INC    = 4'b0000;
  localparam logic [3:0] S_PASS_B = 4'b1010;
  localparam logic [3:0] S_PASS_A = 4'b1111;

  localparam logic [2:0] MODE_RUN  = 3'b000;
  localparam logic [2:0] MODE_WMEM = 3'b001;
  localparam logic [2:0] MODE_RMEM = 3'b010;
  localparam logic [2:0] MODE_RREG = 3'b011;
  localparam logic [2:0] MODE_WREG = 3'b100;

  // selctl is carried for datapath compatibility; this controller never raises it
  typedef struct packed {
    logic       drw;
    logic       pcinc;
    logic       lpc;
    logic       lar;
    logic       pcadd;
    logic       arinc;
    logic       selctl;
    logic       memw;
    logic       lir;
    logic       ldz;
    logic       ldc;
    logic       cin;
    logic       m;
    logic       abus;
    logic       sbus;
    logic       mbus;
    logic [3:0] s;
  } ctrl_t;

endpackage

// File: rtl/tec_ctrl_seq_if.sv
// Console/datapath side of the controller: inputs from switches, IR and flags,
// outputs are beat timing, phase, register selects and the datapath controls.
interface tec_ctrl_seq_if
  import tec_ctrl_pkg::*;
#(
  parameter int IR_W   = 4,
  parameter int RSEL_W = 2,
  parameter int BEATS  = 3
);
  // Handshake: start is a one-cycle pulse, accepted only while halted = 1;
  // halted drops on the accepting edge and rises again when the controller
  // returns to IDLE or HALT. Pulses while halted = 0 are ignored.
  logic              start;
  logic [2:0]        sw;
  logic [IR_W-1:0]   ir;
  logic              c;
  logic              z;
  logic              int_req;

  logic [BEATS-1:0]  beat;
  logic              st0;
  logic              halted;
  logic              int_ack;
  logic [RSEL_W-1:0] rd_sel;
  logic [RSEL_W-1:0] rs_sel;

  logic drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw;
  logic lir, ldz, ldc, cin, m, abus, sbus, mbus;
  logic [3:0] s;

  fsm_t dbg_fsm;
  logic dbg_int_en;

  modport master (
    input  start, sw, ir, c, z, int_req,
    output beat, st0, halted, int_ack, rd_sel, rs_sel,
    output drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw,
    output lir, ldz, ldc, cin, m, abus, sbus, mbus, s,
    output dbg_fsm, dbg_int_en
  );

  modport slave (
    output start, sw, ir, c, z, int_req,
    input  beat, st0, halted, int_ack, rd_sel, rs_sel,
    input  drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw,
    input  lir, ldz, ldc, cin, m, abus, sbus, mbus, s,
    input  dbg_fsm, dbg_int_en
  );

endinterface

// File: rtl/tec_ctrl_seq_beat.sv
// One-hot beat generator: W1 -> W2 (-> W3) and back to W1 at cycle end.
// short ends the cycle after W1, long after W3, otherwise after W2.
module tec_beat_gen #(
  parameter int BEATS = 3
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             run,
  input  logic             short,
  input  logic             long,
  output logic [BEATS-1:0] beat,
  output logic             cycle_end
);

  always_comb begin
    cycle_end = beat[1];
    if (short)
      cycle_end = beat[0];
    else if (long)
      cycle_end = beat[2];
  end

  always_ff @(posedge t3) begin
    if (clr)
      beat <= BEATS'(1);
    else if (run)
      beat <= cycle_end ? BEATS'(1) : (beat << 1);
  end

endmodule

// File: rtl/tec_ctrl_seq.sv
// Hardwired controller for the teaching CPU: console modes with the st0
// two-phase scheme, fetch/execute with self-timed beats, EI/DI interrupt.
module tec_ctrl_seq
  import tec_ctrl_pkg::*;
#(
  parameter int IR_W       = 4,
  parameter int NREG       = 4,
  parameter int BEATS      = 3,
  parameter bit INT_EN_RST = 1'b0
) (
  input logic            t3,
  input logic            clr,
  tec_ctrl_seq_if.master bus
);

  localparam int RSEL_W = (NREG > 1) ? $clog2(NREG) : 1;

  fsm_t              fsm, nxt_fsm;
  logic              st0, nxt_st0;
  logic              int_en, nxt_int_en;
  logic              halted_q;
  logic [2:0]        mode;
  logic [BEATS-1:0]  beat;
  logic              run, cycle_end, short_c, long_c, ack, w1, w2;
  logic [3:0]        op;
  logic [RSEL_W-1:0] rd, rs;
  ctrl_t             ctrl;

  assign run = ~halted_q;
  assign w1  = beat[0];
  assign w2  = beat[1];

  tec_beat_gen #(.BEATS(BEATS)) u_beat (
    .t3        (t3),
    .clr       (clr),
    .run       (run),
    .short     (short_c),
    .long      (long_c),
    .beat      (beat),
    .cycle_end (cycle_end)
  );

  // Any set bit above the 4-bit opcode field turns the instruction into a NOP
  assign op = ((bus.ir >> 4) == '0) ? bus.ir[3:0] : OP_NOP;

  always_comb begin
    ctrl       = '0;
    rd         = '0;
    rs         = '0;
    ack        = 1'b0;
    short_c    = 1'b0;
    long_c     = 1'b0;
    nxt_fsm    = fsm;
    nxt_st0    = st0;
    nxt_int_en = int_en;
    case (fsm)
      ST_CON: begin
        nxt_fsm = ST_IDLE;
        case (mode)
          MODE_WREG: begin
            ctrl.sbus = 1'b1;
            ctrl.drw  = 1'b1;
            if (w1) rd = st0 ? RSEL_W'(2) : RSEL_W'(0);
            else    rd = st0 ? RSEL_W'(3) : RSEL_W'(1);
            nxt_st0 = ~st0;
          end
          MODE_RREG: begin
            rs = w1 ? RSEL_W'(0) : RSEL_W'(2);
            rd = w1 ? RSEL_W'(1) : RSEL_W'(3);
          end
          MODE_RMEM, MODE_WMEM: begin
            short_c = 1'b1;
            if (!st0) begin
              ctrl.sbus = 1'b1;
              ctrl.lar  = 1'b1;
              nxt_st0   = 1'b1;
            end else if (mode == MODE_RMEM) begin
              ctrl.mbus  = 1'b1;
              ctrl.arinc = 1'b1;
            end else begin
              ctrl.sbus  = 1'b1;
              ctrl.memw  = 1'b1;
              ctrl.arinc = 1'b1;
            end
          end
          MODE_RUN: begin
            short_c = 1'b1;
            if (!st0) begin
              ctrl.sbus = 1'b1;
              ctrl.lpc  = 1'b1;
              nxt_st0   = 1'b1;
            end
          end
          default: short_c = 1'b1;
        endcase
      end
      ST_FETCH: begin
        short_c    = 1'b1;
        ctrl.lir   = 1'b1;
        ctrl.pcinc = 1'b1;
        nxt_fsm    = ST_EXEC;
      end
      ST_EXEC: begin
        case (op)
          OP_ADD: if (w1) begin
            ctrl.s = S_ADD; ctrl.cin = 1'b1; ctrl.abus = 1'b1;
            ctrl.drw = 1'b1; ctrl.ldz = 1'b1; ctrl.ldc = 1'b1;
          end
          OP_SUB: if (w1) begin
            ctrl.s = S_SUB; ctrl.abus = 1'b1;
            ctrl.drw = 1'b1; ctrl.ldz = 1'b1; ctrl.ldc = 1'b1;
          end
          OP_AND: if (w1) begin
            ctrl.m = 1'b1; ctrl.s = S_AND; ctrl.abus = 1'b1;
            ctrl.drw = 1'b1; ctrl.ldz = 1'b1;
          end
          OP_INC: if (w1) begin
            ctrl.s = S_INC; ctrl.abus = 1'b1;
            ctrl.drw = 1'b1; ctrl.ldz = 1'b1; ctrl.ldc = 1'b1;
          end
          OP_LD: begin
            long_c = 1'b1;
            if (w1) begin
              ctrl.m = 1'b1; ctrl.s = S_PASS_B; ctrl.abus = 1'b1; ctrl.lar = 1'b1;
            end else if (w2) begin
              ctrl.mbus = 1'b1; ctrl.drw = 1'b1;
            end
          end
          OP_ST: begin
            long_c = 1'b1;
            if (w1) begin
              ctrl.m = 1'b1; ctrl.s = S_PASS_A; ctrl.abus = 1'b1; ctrl.lar = 1'b1;
            end else if (w2) begin
              ctrl.m = 1'b1; ctrl.s = S_PASS_B; ctrl.abus = 1'b1; ctrl.memw = 1'b1;
            end
          end
          OP_JC: begin
            short_c    = 1'b1;
            ctrl.pcadd = bus.c;
          end
          OP_JZ: begin
            short_c    = 1'b1;
            ctrl.pcadd = bus.z;
          end
          OP_JMP: begin
            short_c = 1'b1;
            ctrl.m = 1'b1; ctrl.s = S_PASS_A; ctrl.abus = 1'b1; ctrl.lpc = 1'b1;
          end
          OP_EI: begin
            short_c    = 1'b1;
            nxt_int_en = 1'b1;
          end
          OP_DI: begin
            short_c    = 1'b1;
            nxt_int_en = 1'b0;
          end
          default: short_c = 1'b1;
        endcase
        // The interrupt test uses the enable as it stood before this instruction
        if (op == OP_STP)
          nxt_fsm = ST_HALT;
        else if (int_en && bus.int_req)
          nxt_fsm = ST_INT;
        else
          nxt_fsm = ST_FETCH;
      end
      ST_INT: begin
        short_c    = 1'b1;
        ack        = 1'b1;
        ctrl.sbus  = 1'b1;
        ctrl.lpc   = 1'b1;
        nxt_int_en = 1'b0;
        nxt_fsm    = ST_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge t3) begin
    if (clr) begin
      fsm      <= ST_IDLE;
      st0      <= 1'b0;
      int_en   <= INT_EN_RST;
      mode     <= MODE_RUN;
      halted_q <= 1'b1;
    end else begin
      case (fsm)
        ST_IDLE: if (bus.start) begin
          mode     <= bus.sw;
          halted_q <= 1'b0;
          fsm      <= (bus.sw == MODE_RUN && st0) ? ST_FETCH : ST_CON;
        end
        ST_HALT: if (bus.start) begin
          halted_q <= 1'b0;
          fsm      <= ST_FETCH;
        end
        default: if (cycle_end) begin
          fsm      <= nxt_fsm;
          st0      <= nxt_st0;
          int_en   <= nxt_int_en;
          halted_q <= (nxt_fsm == ST_IDLE) || (nxt_fsm == ST_HALT);
        end
      endcase
    end
  end

  assign bus.beat       = beat;
  assign bus.st0        = st0;
  assign bus.halted     = halted_q;
  assign bus.int_ack    = ack;
  assign bus.rd_sel     = rd;
  assign bus.rs_sel     = rs;
  assign bus.dbg_fsm    = fsm;
  assign bus.dbg_int_en = int_en;

  assign bus.drw    = ctrl.drw;
  assign bus.pcinc  = ctrl.pcinc;
  assign bus.lpc    = ctrl.lpc;
  assign bus.lar    = ctrl.lar;
  assign bus.pcadd  = ctrl.pcadd;
  assign bus.arinc  = ctrl.arinc;
  assign bus.selctl = ctrl.selctl;
  assign bus.memw   = ctrl.memw;
  assign bus.lir    = ctrl.lir;
  assign bus.ldz    = ctrl.ldz;
  assign bus.ldc    = ctrl.ldc;
  assign bus.cin    = ctrl.cin;
  assign bus.m      = ctrl.m;
  assign bus.abus   = ctrl.abus;
  assign bus.sbus   = ctrl.sbus;
  assign bus.mbus   = ctrl.mbus;
  assign bus.s      = ctrl.s;

endmodule
